// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: state encoding and address-check helpers shared by memory responders
package data_mem_responder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;
  localparam int XLEN = 32;
  localparam int WORD_LSB = 2;
  localparam int CNT_W = 4;
  // Misaligned (low byte-offset bits set) or beyond the RAM's word range
  function automatic logic addr_err(input logic [XLEN-1:0] addr, input int aw);
    return (addr[WORD_LSB-1:0] != '0) || ((addr >> (aw + WORD_LSB)) != '0);
  endfunction
endpackage

// File: rtl/data_mem_responder_mem_array.sv
// data_mem_responder_mem_array: single-port word RAM with a registered, enable-held read port
module data_mem_responder_mem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q, rdata_d;
  // Read data only moves on a read strobe so it stays stable while a response waits
  always_comb rdata_d = re ? mem[addr] : rdata_q;
  // Array write and read-data register
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data-port responder over a wait-stated word RAM
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_STATES - 1);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               err_q, err_d;
  logic               load_q, load_d;
  logic               acc_err, ram_we, ram_re;
  logic [31:0]        ram_rdata;
  assign acc_err = addr_err(addr_q, ADDR_WIDTH);
  // Next-state, request latching, wait counting and RAM strobes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    load_d      = load_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    case (state_q)
      ST_IDLE: if (REQ_VALID && req_ready_q) begin
        write_d     = REQ_WRITE;
        addr_d      = REQ_ADDR;
        wdata_d     = REQ_WDATA;
        cnt_d       = '0;
        req_ready_d = 1'b0;
        state_d     = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST_CNT) ? ST_ACCESS : ST_WAIT;
      end
      ST_ACCESS: begin
        ram_we      = write_q && !acc_err;
        ram_re      = !write_q && !acc_err;
        err_d       = acc_err;
        load_d      = !write_q && !acc_err;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: if (RSP_READY) begin
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        load_d      = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // State and registered outputs; RAM contents survive reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      load_q      <= load_d;
    end
  end
  data_mem_responder_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q[ADDR_WIDTH+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );
  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ERR   = err_q;
  assign RSP_RDATA = load_q ? ram_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the data-port responder at 2 and 0 wait states
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_write, rsp_ready, sel;
  logic [31:0] req_addr, req_wdata;
  logic        rdy0, rv0, er0, rdy1, rv1, er1;
  logic [31:0] rd0, rd1;
  logic        rdy, rv, er;
  logic [31:0] rd;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_ws2 (
    .CLK(clk), .nRST(rst_n), .REQ_VALID(req_valid), .REQ_READY(rdy0), .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .RSP_VALID(rv0), .RSP_READY(rsp_ready),
    .RSP_RDATA(rd0), .RSP_ERR(er0)
  );
  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_ws0 (
    .CLK(clk), .nRST(rst_n), .REQ_VALID(req_valid), .REQ_READY(rdy1), .REQ_WRITE(req_write),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .RSP_VALID(rv1), .RSP_READY(rsp_ready),
    .RSP_RDATA(rd1), .RSP_ERR(er1)
  );
  assign rdy = sel ? rdy1 : rdy0;
  assign rv  = sel ? rv1  : rv0;
  assign er  = sel ? er1  : er0;
  assign rd  = sel ? rd1  : rd0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, output int lat);
    int w = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    while (!rdy && w < 64) begin @(posedge clk); #1; w++; end
    chk("req_ready_before_accept", rdy, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    lat = 1;
    while (!rv && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("rsp_valid_arrives", rv, 1);
  endtask
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic err, output int lat);
    rsp_ready = 1'b1;
    issue(wr, a, d, lat);
    rdata = rd; err = er;
    @(posedge clk); #1;
    chk("idle_after_rsp_ready", rdy, 1);
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, rdy, 1);
    chk({tag, "_rsp_valid"}, rv, 0);
    chk({tag, "_rsp_rdata"}, rd, 0);
    chk({tag, "_rsp_err"}, er, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] r;
    logic        e;
    int          l;
    sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    // 1: store then load, four-cycle latency at two wait states
    txn(1'b1, 32'h10, 32'hDEADBEEF, r, e, l);
    chk("st10_err", e, 0); chk("st10_rdata", r, 0); chk("st10_lat", l, 4);
    txn(1'b0, 32'h10, 32'h0, r, e, l);
    chk("ld10_rdata", r, 32'hDEADBEEF); chk("ld10_err", e, 0); chk("ld10_lat", l, 4);
    // 2: misaligned and out-of-range accesses
    txn(1'b0, 32'h13, 32'h0, r, e, l);
    chk("ld13_err", e, 1); chk("ld13_rdata", r, 0);
    txn(1'b1, 32'h12, 32'h11111111, r, e, l);
    chk("st12_err", e, 1);
    txn(1'b1, 32'h402, 32'h22222222, r, e, l);
    chk("st402_err", e, 1);
    txn(1'b0, 32'h10, 32'h0, r, e, l);
    chk("ld10_unchanged", r, 32'hDEADBEEF); chk("ld10_unchanged_err", e, 0);
    txn(1'b0, 32'h400, 32'h0, r, e, l);
    chk("ld400_err", e, 1); chk("ld400_rdata", r, 0);
    // 3: response held under back-pressure, new requests ignored
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, l);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rv, 1);
      chk("hold_rdata", rd, 32'hDEADBEEF);
      chk("hold_err", er, 0);
      chk("hold_req_ready", rdy, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_write = 1'b0;
    rsp_ready = 1'b1;
    chk("hold_still_valid", rv, 1);
    @(posedge clk); #1;
    chk("hold_released_valid", rv, 0);
    chk("hold_released_ready", rdy, 1);
    txn(1'b0, 32'h10, 32'h0, r, e, l);
    chk("ld10_after_ignored_store", r, 32'hDEADBEEF);
    // 4: reset during WAIT aborts the store
    txn(1'b1, 32'h20, 32'hCAFEF00D, r, e, l);
    chk("st20_err", e, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    chk("wait_req_ready", rdy, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("abort");
    rst_n = 1'b1;
    txn(1'b0, 32'h20, 32'h0, r, e, l);
    chk("ld20_old", r, 32'hCAFEF00D); chk("ld20_err", e, 0);
    // 6: top word in range, one past it out of range
    txn(1'b1, 32'h3FC, 32'hA5A55A5A, r, e, l);
    chk("st3fc_err", e, 0);
    txn(1'b0, 32'h3FC, 32'h0, r, e, l);
    chk("ld3fc_rdata", r, 32'hA5A55A5A); chk("ld3fc_err", e, 0);
    txn(1'b0, 32'h400, 32'h0, r, e, l);
    chk("ld_top_plus4_err", e, 1); chk("ld_top_plus4_rdata", r, 0);
    // 5: zero wait states, back-to-back stores then loads
    sel = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_vals("ws0_reset");
    for (int k = 0; k < 3; k++) begin
      txn(1'b1, 32'(4 * k), 32'h1000 + 32'(k), r, e, l);
      chk("ws0_st_lat", l, 2); chk("ws0_st_err", e, 0);
    end
    for (int k = 0; k < 3; k++) begin
      txn(1'b0, 32'(4 * k), 32'h0, r, e, l);
      chk("ws0_ld_rdata", r, 32'h1000 + 32'(k)); chk("ws0_ld_lat", l, 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
